// File: rtl/mdv_unit_pkg.sv
// ----------------------------------------------------------------------------
// mdv_unit_pkg
// Shared types for the multiply/divide unit:
//   MDV_OP    - EX-stage multiply/divide/HI-LO move operation selector
//   MDV_STATE - sequencer state of mdv_unit (IDLE, MULT, DIV)
// ----------------------------------------------------------------------------
package mdv_unit_pkg;

    typedef enum logic [3:0] {
        MDV_none  = 4'd0,
        MDV_mult  = 4'd1,
        MDV_multu = 4'd2,
        MDV_div   = 4'd3,
        MDV_divu  = 4'd4,
        MDV_mthi  = 4'd5,
        MDV_mtlo  = 4'd6,
        MDV_mfhi  = 4'd7,
        MDV_mflo  = 4'd8
    } MDV_OP;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2
    } MDV_STATE;

    function automatic logic is_mult(input MDV_OP op);
        return (op == MDV_mult) || (op == MDV_multu);
    endfunction

endpackage

// File: rtl/mdv_unit.sv
// ----------------------------------------------------------------------------
// mdv_unit
// Multiply/divide sequencer for the five-stage pipeline. Computes the 64-bit
// result at issue, holds the unit busy for a fixed latency, then commits the
// result into the architectural HI/LO registers.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   start        - EX-stage mult/multu/div/divu issue strobe
//   MDVop        - EX-stage operation
//   A, B         - EX-stage rs / rt operands
//   Req          - exception/interrupt; EX instruction is being flushed
//   id_md        - ID-stage instruction is an MDV instruction
//   busy, stall  - unit occupied / ID-stage stall request
//   HI, LO       - architectural HI/LO
//   ans          - mfhi/mflo read data (0 for other ops)
// ----------------------------------------------------------------------------
module mdv_unit
    import mdv_unit_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  MDV_OP       MDVop,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Req,
    input  logic        id_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] ans
);

    localparam int unsigned MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CW   = $clog2(MAXC) + 1;

    MDV_STATE      state, state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   hi_t, lo_t;
    logic          wr_t;       // pending result is to be committed (clear on divide by zero)

    logic [63:0]        prod_s, prod_u;
    logic [31:0]        b_nz;
    logic signed [32:0] dvd_s, dvs_s;
    logic [31:0]        quo_s, rem_s, quo_u, rem_u;
    logic [31:0]        res_hi, res_lo;
    logic               res_wr;
    logic               issue;

    assign issue = start && !Req;

    // Divisor forced non-zero so the dividers never see 0; the result is
    // discarded in that case via res_wr.
    assign b_nz   = (B == '0) ? 32'd1 : B;
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};
    // 33-bit signed operands make 0x80000000 / -1 yield +2^31, whose low
    // 32 bits are the required 0x80000000 with remainder 0.
    assign dvd_s  = $signed({A[31], A});
    assign dvs_s  = $signed({b_nz[31], b_nz});
    assign quo_s  = 32'(dvd_s / dvs_s);
    assign rem_s  = 32'(dvd_s % dvs_s);
    assign quo_u  = A / b_nz;
    assign rem_u  = A % b_nz;

    always_comb begin
        res_hi = '0;
        res_lo = '0;
        res_wr = 1'b0;
        case (MDVop)
            MDV_mult:  begin {res_hi, res_lo} = prod_s; res_wr = 1'b1; end
            MDV_multu: begin {res_hi, res_lo} = prod_u; res_wr = 1'b1; end
            MDV_div:   begin res_hi = rem_s; res_lo = quo_s; res_wr = (B != '0); end
            MDV_divu:  begin res_hi = rem_u; res_lo = quo_u; res_wr = (B != '0); end
            default:   ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:      if (issue) state_nxt = is_mult(MDVop) ? MULT : DIV;
            MULT, DIV: if (cnt == CW'(1)) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            HI    <= '0;
            LO    <= '0;
            hi_t  <= '0;
            lo_t  <= '0;
            wr_t  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) begin
                if (issue) begin
                    hi_t <= res_hi;
                    lo_t <= res_lo;
                    wr_t <= res_wr;
                    cnt  <= is_mult(MDVop) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                end else if (!Req && MDVop == MDV_mthi) begin
                    HI <= A;
                end else if (!Req && MDVop == MDV_mtlo) begin
                    LO <= A;
                end
            end else begin
                cnt <= cnt - CW'(1);
                if (cnt == CW'(1) && wr_t) begin
                    HI <= hi_t;
                    LO <= lo_t;
                end
            end
        end
    end

    assign busy  = start || (state != IDLE);
    assign stall = id_md && busy;

    always_comb begin
        ans = '0;
        if (MDVop == MDV_mfhi)      ans = HI;
        else if (MDVop == MDV_mflo) ans = LO;
    end

endmodule
